// File: rtl/enemy_step_scheduler_if.sv
// Step offer channel between the scheduler and the enemy position-update datapath.
interface enemy_step_scheduler_if #(
  parameter int unsigned IDW = 2
);
  logic           step_valid;
  logic [IDW-1:0] step_id;
  logic           step_ready;

  modport master (output step_valid, output step_id, input step_ready);
  modport slave  (input step_valid, input step_id, output step_ready);
endinterface

// File: rtl/enemy_step_scheduler.sv
// Shared-tick enemy pacing: per-slot phase accumulators raise pending steps,
// which are round-robin offered one at a time to the position-update datapath.
module enemy_step_scheduler #(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned SPD_W   = 8,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned IDW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [N_SLOTS-1:0]   slot_active,
  input  logic                 cfg_we,
  input  logic [IDW-1:0]       cfg_id,
  input  logic [SPD_W-1:0]     cfg_speed,
  enemy_step_scheduler_if.master step,
  output logic [N_SLOTS-1:0]   pending,
  output logic                 overrun
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  state_t           state;
  logic [SPD_W-1:0] speed [N_SLOTS];
  logic [ACC_W-1:0] acc   [N_SLOTS];
  logic [IDW-1:0]   ptr;

  logic [SUM_W-1:0]   sum [N_SLOTS];
  logic [N_SLOTS-1:0] carry_vec;
  logic [N_SLOTS-1:0] id_onehot;
  logic [N_SLOTS-1:0] grant_vec;
  logic [N_SLOTS-1:0] ovr_vec;
  logic [N_SLOTS-1:0] pend_nxt;
  logic [N_SLOTS-1:0] avail;
  logic               id_active;
  logic               handshake;
  logic               sel_found;
  logic [IDW-1:0]     sel_idx;
  logic [IDW-1:0]     ptr_inc;

  // Decode the offered slot and whether the offer completes at this edge.
  always_comb begin
    id_onehot = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      id_onehot[i] = (step.step_id == IDW'(i));
    end
    id_active = |(slot_active & id_onehot);
    handshake = (state == S_OFFER) && step.step_ready && id_active;
    grant_vec = handshake ? id_onehot : '0;
    ptr_inc   = (step.step_id == IDW'(N_SLOTS - 1)) ? '0 : step.step_id + IDW'(1);
  end

  // Per-slot accumulate, carry detection and pending/overrun next state.
  always_comb begin
    carry_vec = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      sum[i]       = {1'b0, acc[i]} + SUM_W'(speed[i]);
      carry_vec[i] = tick && slot_active[i] && sum[i][ACC_W];
    end
    // A grant and a carry on the same slot merge into a fresh pending step.
    ovr_vec  = carry_vec & pending & ~grant_vec;
    pend_nxt = slot_active & ((pending & ~grant_vec) | carry_vec);
  end

  // Round-robin search for the first live pending slot at or after ptr.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    avail     = pending & slot_active;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_SLOTS) begin
        cand = cand - N_SLOTS;
      end
      if (!sel_found && avail[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  // Speed registers, accumulators, pending flags and overrun pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        speed[i] <= '0;
        acc[i]   <= '0;
      end
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      if (cfg_we) begin
        speed[cfg_id] <= cfg_speed;
      end
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        if (!slot_active[i]) begin
          acc[i] <= '0;
        end else if (tick) begin
          acc[i] <= sum[i][ACC_W-1:0];
        end
      end
      pending <= pend_nxt;
      overrun <= |ovr_vec;
    end
  end

  // Offer FSM: IDLE picks a slot, OFFER holds it until accepted or withdrawn.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      step.step_valid <= 1'b0;
      step.step_id    <= '0;
      ptr             <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          step.step_valid <= 1'b0;
          if (sel_found) begin
            step.step_id    <= sel_idx;
            step.step_valid <= 1'b1;
            state           <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (!id_active) begin
            // Enemy vanished before acceptance: drop the offer, keep ptr.
            step.step_valid <= 1'b0;
            state           <= S_IDLE;
          end else if (step.step_ready) begin
            step.step_valid <= 1'b0;
            ptr             <= ptr_inc;
            state           <= S_IDLE;
          end
        end
        default: begin
          step.step_valid <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_step_scheduler.sv
// Bench for enemy_step_scheduler: directed scenarios with literal expectations
// plus randomized traffic, all compared each cycle against a behavioural model.
module tb_enemy_step_scheduler;

  localparam int N = 4;
  localparam int MODV = 65536;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] slot_active = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_id = '0;
  logic [7:0] cfg_speed = '0;
  logic       step_ready = 1'b0;
  logic [3:0] pending;
  logic       overrun;

  enemy_step_scheduler_if #(.IDW(2)) sif ();
  assign sif.step_ready = step_ready;

  enemy_step_scheduler #(.N_SLOTS(4), .SPD_W(8), .ACC_W(16), .IDW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .slot_active (slot_active),
    .cfg_we      (cfg_we),
    .cfg_id      (cfg_id),
    .cfg_speed   (cfg_speed),
    .step        (sif),
    .pending     (pending),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: integer phase, set of pending slots, one outstanding offer.
  int m_speed [N];
  int m_acc   [N];
  bit m_pend  [N];
  bit m_valid;
  int m_id;
  int m_ptr;
  bit m_ovr;
  bit m_live = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_speed[i] = 0;
        m_acc[i]   = 0;
        m_pend[i]  = 1'b0;
      end
      m_valid = 1'b0;
      m_id    = 0;
      m_ptr   = 0;
      m_ovr   = 1'b0;
      m_live  = 1'b1;
    end else begin
      bit accepted;
      bit withdrawn;
      bit any_drop;
      bit found;
      bit np [N];
      int na [N];
      int total;
      bit carry;
      bit granted;
      accepted  = m_valid && step_ready && slot_active[m_id];
      withdrawn = m_valid && !slot_active[m_id];
      any_drop  = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!slot_active[i]) begin
          na[i] = 0;
          np[i] = 1'b0;
        end else begin
          total   = m_acc[i] + m_speed[i];
          carry   = tick && (total >= MODV);
          na[i]   = tick ? (total % MODV) : m_acc[i];
          granted = accepted && (m_id == i);
          np[i]   = (m_pend[i] && !granted) || carry;
          if (carry && m_pend[i] && !granted) any_drop = 1'b1;
        end
      end
      if (!m_valid) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!found && m_pend[j] && slot_active[j]) begin
            found   = 1'b1;
            m_valid = 1'b1;
            m_id    = j;
          end
        end
      end else if (withdrawn) begin
        m_valid = 1'b0;
      end else if (accepted) begin
        m_valid = 1'b0;
        m_ptr   = (m_id + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        m_acc[i]  = na[i];
        m_pend[i] = np[i];
      end
      m_ovr = any_drop;
      if (cfg_we) m_speed[cfg_id] = int'(cfg_speed);
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      logic [3:0] mp;
      for (int i = 0; i < N; i++) mp[i] = m_pend[i];
      chk("step_valid", 32'(sif.step_valid), 32'(m_valid));
      chk("step_id", 32'(sif.step_id), 32'(m_id));
      chk("pending", 32'(pending), 32'(mp));
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // Observed handshakes and overrun pulses, for the literal scenario checks.
  int ng = 0;
  int novr = 0;
  int gids [$];
  always @(negedge clk) begin
    if (reset === 1'b1 && sif.step_valid === 1'b1 && step_ready === 1'b1 &&
        slot_active[sif.step_id] === 1'b1) begin
      ng++;
      gids.push_back(int'(sif.step_id));
    end
    if (reset === 1'b1 && overrun === 1'b1) novr++;
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    nxt();
    reset = 1'b1;
  endtask

  task automatic cfg(input int id, input int spd);
    cfg_we    = 1'b1;
    cfg_id    = 2'(id);
    cfg_speed = 8'(spd);
    nxt();
    cfg_we    = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) nxt();
    tick = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (sif.step_valid !== 1'b1 && n < 50) begin
      nxt();
      n++;
    end
    chk("wait_valid", 32'(sif.step_valid), 32'd1);
  endtask

  initial begin
    int g0;
    int o0;
    int hold;
    reset = 1'b0;
    repeat (2) nxt();
    @(negedge clk);
    chk("rst_valid", 32'(sif.step_valid), 32'd0);
    chk("rst_id", 32'(sif.step_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    nxt();

    // Speed rate: 128/65536 per tick gives a step every 512 ticks.
    do_reset();
    slot_active = 4'b0001;
    cfg(0, 128);
    step_ready = 1'b1;
    g0 = ng; o0 = novr;
    ticks(1024);
    repeat (4) nxt();
    chk("rate_grants", 32'(ng - g0), 32'd2);
    if (ng - g0 >= 2) begin
      chk("rate_id0", 32'(gids[g0]), 32'd0);
      chk("rate_id1", 32'(gids[g0 + 1]), 32'd0);
    end
    chk("rate_overrun", 32'(novr - o0), 32'd0);

    // Fairness: all slots carry together, served 0,1,2,3 each round.
    do_reset();
    slot_active = 4'b0000;
    for (int i = 0; i < N; i++) cfg(i, 255);
    slot_active = 4'b1111;
    step_ready = 1'b1;
    g0 = ng; o0 = novr;
    ticks(600);
    repeat (12) nxt();
    chk("fair_grants", 32'(ng - g0), 32'd8);
    if (ng - g0 >= 8) begin
      for (int k = 0; k < 8; k++) chk("fair_order", 32'(gids[g0 + k]), 32'(k % 4));
    end
    chk("fair_overrun", 32'(novr - o0), 32'd0);

    // Backpressure: carries at ticks 258 and 515, second one is dropped.
    do_reset();
    slot_active = 4'b0010;
    cfg(1, 255);
    step_ready = 1'b0;
    o0 = novr;
    ticks(600);
    nxt();
    @(negedge clk);
    chk("bp_overrun", 32'(novr - o0), 32'd1);
    chk("bp_pending", 32'(pending), 32'b0010);
    chk("bp_valid", 32'(sif.step_valid), 32'd1);
    g0 = ng;
    step_ready = 1'b1;
    repeat (6) nxt();
    chk("bp_grants", 32'(ng - g0), 32'd1);
    if (ng - g0 >= 1) chk("bp_id", 32'(gids[g0]), 32'd1);

    // Grant and carry on the same edge: a second step is queued, no overrun.
    do_reset();
    slot_active = 4'b0100;
    cfg(2, 255);
    step_ready = 1'b0;
    ticks(258);
    ticks(256);
    @(negedge clk);
    chk("same_pend_pre", 32'(pending), 32'b0100);
    g0 = ng; o0 = novr;
    tick = 1'b1;
    step_ready = 1'b1;
    nxt();
    tick = 1'b0;
    step_ready = 1'b0;
    @(negedge clk);
    chk("same_pend_post", 32'(pending), 32'b0100);
    chk("same_valid_post", 32'(sif.step_valid), 32'd0);
    step_ready = 1'b1;
    repeat (6) nxt();
    chk("same_grants", 32'(ng - g0), 32'd2);
    if (ng - g0 >= 2) chk("same_id2", 32'(gids[g0 + 1]), 32'd2);
    chk("same_overrun", 32'(novr - o0), 32'd0);

    // Withdraw: dropping the enemy cancels the offer and clears its phase.
    do_reset();
    slot_active = 4'b1000;
    cfg(3, 255);
    step_ready = 1'b0;
    ticks(258);
    wait_valid();
    chk("wd_id", 32'(sif.step_id), 32'd3);
    g0 = ng;
    slot_active = 4'b0000;
    nxt();
    @(negedge clk);
    chk("wd_valid", 32'(sif.step_valid), 32'd0);
    chk("wd_pending", 32'(pending), 32'd0);
    slot_active = 4'b1000;
    ticks(257);
    @(negedge clk);
    chk("wd_acc_cleared", 32'(pending), 32'd0);
    ticks(1);
    @(negedge clk);
    chk("wd_recarry", 32'(pending), 32'b1000);
    chk("wd_grants", 32'(ng - g0), 32'd0);

    // Reset mid-offer, then a speed write coinciding with a tick.
    do_reset();
    slot_active = 4'b0001;
    cfg(0, 255);
    ticks(258);
    wait_valid();
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(sif.step_valid), 32'd0);
    chk("rst_mid_pending", 32'(pending), 32'd0);
    cfg_we = 1'b1; cfg_id = 2'd0; cfg_speed = 8'd200; tick = 1'b1;
    nxt();
    cfg_we = 1'b0; tick = 1'b0;
    ticks(327);
    @(negedge clk);
    chk("cfg_old_speed", 32'(pending), 32'd0);
    ticks(1);
    @(negedge clk);
    chk("cfg_new_speed", 32'(pending), 32'b0001);

    // Randomized traffic against the model.
    do_reset();
    slot_active = 4'b1111;
    step_ready = 1'b1;
    hold = 0;
    for (int c = 0; c < 20000; c++) begin
      cfg_we = 1'b0;
      if ($urandom_range(0, 199) == 0 || c < 4) begin
        cfg_we    = 1'b1;
        cfg_id    = 2'($urandom_range(0, 3));
        cfg_speed = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 63) == 0) slot_active[$urandom_range(0, 3)] ^= 1'b1;
      tick = 1'($urandom_range(0, 1));
      if (hold > 0) begin
        hold--;
        step_ready = 1'b0;
      end else begin
        step_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) hold = $urandom_range(50, 400);
      end
      reset = ($urandom_range(0, 4999) != 0);
      nxt();
    end
    reset = 1'b1;
    cfg_we = 1'b0;
    tick = 1'b0;
    repeat (4) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
